// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// next-PC select codes and the halt opcode.
`default_nettype none

package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_RUN    = 2'd0,
      PC_FLUSH  = 2'd1,
      PC_DRAIN  = 2'd2,
      PC_HALTED = 2'd3
   } pc_state_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;

   localparam logic [3:0] HLT = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
`default_nettype none

module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: redirects, hazard
// stalls, halt/drain/resume, stall watchdog and performance counters.
`default_nettype none

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int STALL_MAX    = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             jump_id,
   input  logic             halt_id,
   input  logic             resume,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int              RUN_W     = $clog2(STALL_MAX + 2);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_MAX);
   localparam logic [2:0]       DRAIN_LD  = 3'(DRAIN_CYCLES);

   pc_state_t        state;
   logic [2:0]       drain;
   logic [RUN_W-1:0] run_q;
   logic             stall_ev;
   logic             redirect_ev;

   // Defaults are the "frozen" outputs used by DRAIN/HALTED; reset overrides
   // combinationally so an async assertion takes effect without a clock.
   always_comb begin
      pc_we       = 1'b0;
      pc_sel      = PC_SEQ;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b1;
      stall_ev    = 1'b0;
      redirect_ev = 1'b0;
      if (!rst) begin
         ifid_flush = 1'b1;
      end else if ((state == PC_RUN || state == PC_FLUSH) && branch_taken) begin
         pc_we       = 1'b1;
         pc_sel      = PC_BR;
         ifid_flush  = 1'b1;
         redirect_ev = 1'b1;
      end else if (state == PC_RUN && jump_id) begin
         pc_we       = 1'b1;
         pc_sel      = PC_JMP;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b0;
         redirect_ev = 1'b1;
      end else if (state == PC_RUN && hazard) begin
         stall_ev = 1'b1;
      end else if (state == PC_RUN && halt_id) begin
         ifid_flush = 1'b1;
      end else if (state == PC_RUN || state == PC_FLUSH) begin
         pc_we      = 1'b1;
         ifid_we    = 1'b1;
         idex_flush = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= PC_RUN;
         drain  <= 3'd0;
         err    <= 1'b0;
         halted <= 1'b0;
      end else begin
         err <= err | (run_q > RUN_LIMIT);
         case (state)
            PC_RUN: begin
               if (branch_taken || jump_id) begin
                  state <= PC_FLUSH;
               end else if (!hazard && halt_id) begin
                  drain <= DRAIN_LD;
                  state <= PC_DRAIN;
               end
            end
            PC_FLUSH: begin
               if (!branch_taken) state <= PC_RUN;
            end
            PC_DRAIN: begin
               drain <= drain - 3'd1;
               if (drain == 3'd1) begin
                  state  <= PC_HALTED;
                  halted <= 1'b1;
               end
            end
            default: begin
               if (resume) begin
                  state  <= PC_RUN;
                  halted <= 1'b0;
               end
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk), .rst (rst), .clr (1'b0), .inc (stall_ev), .q (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk), .rst (rst), .clr (1'b0), .inc (redirect_ev), .q (flush_cnt)
   );

   // Consecutive-stall run length for the watchdog; any non-stall cycle clears it.
   sat_counter #(.W(RUN_W)) u_run_cnt (
      .clk (clk), .rst (rst), .clr (!stall_ev), .inc (stall_ev), .q (run_q)
   );

endmodule

`default_nettype wire
